// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch clocked by 1 Hz / 2 Hz divider outputs, with run/pause, clear and field adjust.
// Define STOPWATCH_SYNC_EN to pass BTN_PAUSE, BTN_RST, ADJ and SEL through two-flop synchronizers.
module stopwatch_counter #(
   parameter int MIN_MAX      = 99,
   parameter int START_PAUSED = 1
) (
   input  logic       CLK_REF,
   input  logic       CLK_RES_N,
   input  logic       CLK_1HZ,
   input  logic       CLK_2HZ,
   input  logic       BTN_PAUSE,
   input  logic       BTN_RST,
   input  logic       ADJ,
   input  logic       SEL,
   output logic [3:0] MIN_T,
   output logic [3:0] MIN_O,
   output logic [3:0] SEC_T,
   output logic [3:0] SEC_O,
   output logic       BLINK,
   output logic [1:0] STATE,
   output logic       WRAP
);

   typedef enum logic [1:0] {
      ST_PAUSED = 2'b00,
      ST_RUN    = 2'b01,
      ST_ADJUST = 2'b10
   } state_t;

   localparam state_t     RESET_STATE = (START_PAUSED != 0) ? ST_PAUSED : ST_RUN;
   localparam logic [3:0] MAX_T       = 4'(MIN_MAX / 10);
   localparam logic [3:0] MAX_O       = 4'(MIN_MAX % 10);

   logic pause_in, rst_in, adj_in, sel_in;

`ifdef STOPWATCH_SYNC_EN
   logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = {BTN_PAUSE, BTN_RST, ADJ, SEL};
      sync2_d = sync1_q;
   end

   always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
      if (!CLK_RES_N) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign {pause_in, rst_in, adj_in, sel_in} = sync2_q;
`else
   assign {pause_in, rst_in, adj_in, sel_in} = {BTN_PAUSE, BTN_RST, ADJ, SEL};
`endif

   state_t     state_q, state_d;
   logic [3:0] min_t_q, min_t_d, min_o_q, min_o_d;
   logic [3:0] sec_t_q, sec_t_d, sec_o_q, sec_o_d;
   logic       blink_q, blink_d, wrap_q, wrap_d;
   logic       clk1_q, clk1_d, clk2_q, clk2_d, pause_q, pause_d;
   logic       tick1, tick2, pause_edge, sec_at_max, min_at_max;

   // Returns {tens, ones} advanced by one; callers handle the field's own upper limit.
   function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
      if (ones == 4'd9) bcd_inc = {tens + 4'd1, 4'd0};
      else              bcd_inc = {tens, ones + 4'd1};
   endfunction

   assign tick1      = CLK_1HZ & ~clk1_q;
   assign tick2      = CLK_2HZ & ~clk2_q;
   assign pause_edge = pause_in & ~pause_q;
   assign sec_at_max = (sec_t_q == 4'd5) && (sec_o_q == 4'd9);
   assign min_at_max = (min_t_q == MAX_T) && (min_o_q == MAX_O);

   always_comb begin
      state_d = state_q;
      min_t_d = min_t_q;
      min_o_d = min_o_q;
      sec_t_d = sec_t_q;
      sec_o_d = sec_o_q;
      blink_d = blink_q;
      wrap_d  = 1'b0;
      clk1_d  = CLK_1HZ;
      clk2_d  = CLK_2HZ;
      pause_d = pause_in;

      if (rst_in) begin
         {min_t_d, min_o_d, sec_t_d, sec_o_d} = 16'h0000;
      end else if (adj_in) begin
         state_d = ST_ADJUST;
         if (tick2) begin
            blink_d = ~blink_q;
            if (sel_in) begin
               if (min_at_max) {min_t_d, min_o_d} = 8'h00;
               else            {min_t_d, min_o_d} = bcd_inc(min_t_q, min_o_q);
            end else begin
               if (sec_at_max) {sec_t_d, sec_o_d} = 8'h00;
               else            {sec_t_d, sec_o_d} = bcd_inc(sec_t_q, sec_o_q);
            end
         end
      end else if (state_q == ST_ADJUST) begin
         state_d = ST_PAUSED;
         blink_d = 1'b0;
      end else begin
         // Count against the current state first; a coincident pause edge only affects later ticks.
         if ((state_q == ST_RUN) && tick1) begin
            if (!sec_at_max) begin
               {sec_t_d, sec_o_d} = bcd_inc(sec_t_q, sec_o_q);
            end else if (!min_at_max) begin
               {sec_t_d, sec_o_d} = 8'h00;
               {min_t_d, min_o_d} = bcd_inc(min_t_q, min_o_q);
            end else begin
               {min_t_d, min_o_d, sec_t_d, sec_o_d} = 16'h0000;
               wrap_d = 1'b1;
            end
         end
         if (pause_edge) state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
      end
   end

   always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
      if (!CLK_RES_N) begin
         state_q <= RESET_STATE;
         min_t_q <= 4'd0;
         min_o_q <= 4'd0;
         sec_t_q <= 4'd0;
         sec_o_q <= 4'd0;
         blink_q <= 1'b0;
         wrap_q  <= 1'b0;
         clk1_q  <= 1'b0;
         clk2_q  <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         min_t_q <= min_t_d;
         min_o_q <= min_o_d;
         sec_t_q <= sec_t_d;
         sec_o_q <= sec_o_d;
         blink_q <= blink_d;
         wrap_q  <= wrap_d;
         clk1_q  <= clk1_d;
         clk2_q  <= clk2_d;
         pause_q <= pause_d;
      end
   end

   assign MIN_T = min_t_q;
   assign MIN_O = min_o_q;
   assign SEC_T = sec_t_q;
   assign SEC_O = sec_o_q;
   assign BLINK = blink_q;
   assign STATE = state_q;
   assign WRAP  = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus randomized inputs against a
// seconds-count reference model. Honors STOPWATCH_SYNC_EN by delaying the button inputs two cycles.
module tb_stopwatch_counter;

   localparam int MIN_MAX = 99;

   logic       CLK_REF = 1'b0;
   logic       CLK_RES_N = 1'b0;
   logic       clk1 = 1'b0, clk2 = 1'b0;
   logic       btnPause = 1'b0, btnRst = 1'b0, adjIn = 1'b0, selIn = 1'b0;
   logic [3:0] MIN_T, MIN_O, SEC_T, SEC_O;
   logic       BLINK, WRAP;
   logic [1:0] STATE;

   int checkCount = 0;
   int passCount  = 0;

   // Reference model: time kept as plain minutes/seconds integers
   int         mMin, mSec, mState;
   bit         mBlink, mWrap, mPrev1, mPrev2, mPrevPause;
   logic [3:0] effQ[$];

   stopwatch_counter #(.MIN_MAX(MIN_MAX), .START_PAUSED(1)) dut (
      .CLK_REF(CLK_REF), .CLK_RES_N(CLK_RES_N), .CLK_1HZ(clk1), .CLK_2HZ(clk2),
      .BTN_PAUSE(btnPause), .BTN_RST(btnRst), .ADJ(adjIn), .SEL(selIn),
      .MIN_T(MIN_T), .MIN_O(MIN_O), .SEC_T(SEC_T), .SEC_O(SEC_O),
      .BLINK(BLINK), .STATE(STATE), .WRAP(WRAP)
   );

   always #5 CLK_REF = ~CLK_REF;

   task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
   endtask

   task modelReset();
      mMin = 0; mSec = 0; mState = 0;
      mBlink = 0; mWrap = 0; mPrev1 = 0; mPrev2 = 0; mPrevPause = 0;
      effQ = '{4'd0, 4'd0};
   endtask

   task modelStep();
      logic [3:0] eff;
      bit t1, t2, pe;
      int total;
`ifdef STOPWATCH_SYNC_EN
      eff = effQ.pop_front();
      effQ.push_back({btnPause, btnRst, adjIn, selIn});
`else
      eff = {btnPause, btnRst, adjIn, selIn};
`endif
      t1 = clk1 && !mPrev1;
      t2 = clk2 && !mPrev2;
      pe = eff[3] && !mPrevPause;
      mPrev1 = clk1; mPrev2 = clk2; mPrevPause = eff[3];
      mWrap = 0;
      if (eff[2]) begin
         mMin = 0; mSec = 0;
      end else if (eff[1]) begin
         mState = 2;
         if (t2) begin
            mBlink = !mBlink;
            if (eff[0]) mMin = (mMin == MIN_MAX) ? 0 : mMin + 1;
            else        mSec = (mSec + 1) % 60;
         end
      end else if (mState == 2) begin
         mState = 0;
         mBlink = 0;
      end else begin
         if (mState == 1 && t1) begin
            total = mMin * 60 + mSec + 1;
            if (total == (MIN_MAX + 1) * 60) begin
               total = 0;
               mWrap = 1;
            end
            mMin = total / 60;
            mSec = total % 60;
         end
         if (pe) mState = (mState == 1) ? 0 : 1;
      end
   endtask

   function automatic logic [31:0] expDigits();
      return 32'(((mMin / 10) << 12) | ((mMin % 10) << 8) | ((mSec / 10) << 4) | (mSec % 10));
   endfunction

   // One clock: advance model at the edge, compare all outputs just after it
   task applyStimulus();
      @(posedge CLK_REF);
      if (!CLK_RES_N) modelReset();
      else modelStep();
      #1;
      checkOutput("digits", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, expDigits());
      checkOutput("state", {30'h0, STATE}, 32'(mState));
      checkOutput("blink", {31'h0, BLINK}, {31'h0, mBlink});
      checkOutput("wrap", {31'h0, WRAP}, {31'h0, mWrap});
   endtask

   task idle(input int n);
      repeat (n) applyStimulus();
   endtask

   task secondPulse();
      clk1 = 1'b1; idle(2);
      clk1 = 1'b0; idle(2);
   endtask

   task halfPulse();
      clk2 = 1'b1; idle(1);
      clk2 = 1'b0; idle(1);
   endtask

   task pressPause();
      btnPause = 1'b1; idle(2);
      btnPause = 1'b0; idle(4);
   endtask

   initial begin
      modelReset();
      idle(3);
      checkOutput("reset_digits", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0);
      checkOutput("reset_state", {30'h0, STATE}, 32'd0);
      CLK_RES_N = 1'b1;
      idle(2);

      // Start from pause, count three seconds
      pressPause();
      checkOutput("t1_state", {30'h0, STATE}, 32'd1);
      repeat (3) secondPulse();
      idle(3);
      checkOutput("t1_digits", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0003);

      // Preload 99:58 through ADJUST, then run across the wrap
      adjIn = 1'b1; selIn = 1'b1; idle(3);
      repeat (99) halfPulse();
      selIn = 1'b0; idle(3);
      repeat (55) halfPulse();
      adjIn = 1'b0; idle(3);
      checkOutput("t2_preload", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h9958);
      checkOutput("t2_exit_state", {30'h0, STATE}, 32'd0);
      pressPause();
      secondPulse();
      checkOutput("t2_9959", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h9959);
      clk1 = 1'b1; idle(1);
      checkOutput("t2_wrap_pulse", {31'h0, WRAP}, 32'd1);
      checkOutput("t2_wrap_digits", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0000);
      idle(1);
      checkOutput("t2_wrap_end", {31'h0, WRAP}, 32'd0);
      clk1 = 1'b0; idle(2);

      // Carry from 00:59 in RUN; no carry from seconds field in ADJUST
      adjIn = 1'b1; selIn = 1'b0; idle(3);
      repeat (59) halfPulse();
      adjIn = 1'b0; idle(3);
      pressPause();
      secondPulse();
      checkOutput("t3_carry", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0100);
      pressPause();
      adjIn = 1'b1; idle(3);
      repeat (59) halfPulse();
      checkOutput("t3_0159", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0159);
      halfPulse();
      checkOutput("t3_nocarry", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0100);
      adjIn = 1'b0; idle(3);

      // Pause edge coincident with a 1 Hz tick: tick still counts
      pressPause();
      clk1 = 1'b1; btnPause = 1'b1; idle(2);
      clk1 = 1'b0; btnPause = 1'b0; idle(4);
      checkOutput("t4_digits", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0101);
      checkOutput("t4_state", {30'h0, STATE}, 32'd0);

      // Clear held while running
      pressPause();
      btnRst = 1'b1; idle(3);
      repeat (2) secondPulse();
      checkOutput("t5_cleared", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0000);
      checkOutput("t5_state", {30'h0, STATE}, 32'd1);
      btnRst = 1'b0; idle(3);
      secondPulse();
      checkOutput("t5_resume", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0001);

      // Asynchronous reset in ADJUST with BLINK high
      adjIn = 1'b1; idle(3);
      halfPulse();
      checkOutput("t6_blink_set", {31'h0, BLINK}, 32'd1);
      #3 CLK_RES_N = 1'b0;
      #1;
      checkOutput("t6_async_digits", {16'h0, MIN_T, MIN_O, SEC_T, SEC_O}, 32'h0);
      checkOutput("t6_async_blink", {31'h0, BLINK}, 32'd0);
      checkOutput("t6_async_state", {30'h0, STATE}, 32'd0);
      modelReset();
      adjIn = 1'b0;
      idle(2);
      CLK_RES_N = 1'b1;
      idle(2);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) clk1 = ~clk1;
         if ($urandom_range(0, 2) == 0) clk2 = ~clk2;
         if ($urandom_range(0, 9) == 0) btnPause = ~btnPause;
         if (btnRst) btnRst = ($urandom_range(0, 4) != 0);
         else        btnRst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 39) == 0) adjIn = ~adjIn;
         if ($urandom_range(0, 7) == 0) selIn = ~selIn;
         applyStimulus();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
